// File: rtl/tmr_voter_monitor.sv
// tmr_voter_monitor: registered bit-wise TMR majority voter with per-replica error attribution, saturating error counters and sticky persistent-fault flags
// Ports:
//   clk, rstn            rising-edge clock, synchronous active-low reset
//   inA, inB, inC        the three replicas
//   clr                  synchronous clear of counters, run lengths and fail flags
//   out                  voted data (registered when REG_OUT=1, combinational otherwise)
//   tmrErr, errA/B/C     registered: any mismatch / which replica differed from the vote
//   multiErr             registered: two or more replicas differed, attribution ambiguous
//   cntA/B/C             saturating per-replica mismatch counts
//   failA/B/C            sticky: replica differed for PERSIST consecutive cycles
module tmr_voter_monitor #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8,
    parameter int PERSIST   = 4,
    parameter int REG_OUT   = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [WIDTH-1:0]     inA,
    input  logic [WIDTH-1:0]     inB,
    input  logic [WIDTH-1:0]     inC,
    input  logic                 clr,
    output logic [WIDTH-1:0]     out,
    output logic                 tmrErr,
    output logic                 errA,
    output logic                 errB,
    output logic                 errC,
    output logic                 multiErr,
    output logic [CNT_WIDTH-1:0] cntA,
    output logic [CNT_WIDTH-1:0] cntB,
    output logic [CNT_WIDTH-1:0] cntC,
    output logic                 failA,
    output logic                 failB,
    output logic                 failC
);
    localparam int RUN_W = $clog2(PERSIST + 1);
    logic [WIDTH-1:0]     vote;
    logic [2:0]           e;
    logic                 m;
    logic [CNT_WIDTH-1:0] cnt [3];
    logic [RUN_W-1:0]     run [3];
    logic [2:0]           fail;
    assign vote = (inA & inB) | (inA & inC) | (inB & inC);
    assign e    = {|(inA ^ vote), |(inB ^ vote), |(inC ^ vote)};
    assign m    = (e[2] & e[1]) | (e[2] & e[0]) | (e[1] & e[0]);
    always_ff @(posedge clk) begin
        if (!rstn) {tmrErr, errA, errB, errC, multiErr} <= '0;
        else {tmrErr, errA, errB, errC, multiErr} <= {|e, e, m};
    end
    // Index 2/1/0 map to replicas A/B/C; reset and clr both zero the bookkeeping
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rstn || clr) begin
                cnt[k]  <= '0;
                run[k]  <= '0;
                fail[k] <= 1'b0;
            end else if (e[k]) begin
                cnt[k]  <= &cnt[k] ? cnt[k] : cnt[k] + CNT_WIDTH'(1);
                run[k]  <= (run[k] == RUN_W'(PERSIST)) ? run[k] : run[k] + RUN_W'(1);
                fail[k] <= fail[k] | (run[k] == RUN_W'(PERSIST - 1));
            end else begin
                run[k]  <= '0;
            end
        end
    end
    assign {cntA, cntB, cntC}    = {cnt[2], cnt[1], cnt[0]};
    assign {failA, failB, failC} = fail;
    generate
        if (REG_OUT != 0) begin : g_reg
            always_ff @(posedge clk) out <= rstn ? vote : '0;
        end else begin : g_comb
            assign out = vote;
        end
    endgenerate
endmodule
